// File: rtl/tick_countdown_timer.sv
// Seconds countdown timer driven by the board's slow divider tick.
// Synchronises the tick, counts a loaded value down to zero, reports binary/BCD time left.
module tick_countdown_timer #(
  parameter int MAX_SEC = 99,
  parameter int W       = 7
) (
  input  logic         freq_in,
  input  logic         reset_n,
  input  logic         tick_in,
  input  logic         load,
  input  logic [W-1:0] load_sec,
  input  logic         start,
  input  logic         pause,
  input  logic         clear,
  output logic [W-1:0] remaining,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones,
  output logic         running,
  output logic         done,
  output logic         expired
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic [W-1:0] MAX_VAL = W'(MAX_SEC);
  localparam logic [W-1:0] TEN     = W'(10);

  state_e       state_q, state_d;
  logic [W-1:0] remaining_q, remaining_d;
  logic         sync1_q, sync2_q, prev_q;
  logic         running_q, done_q, expired_q;
  logic         tick_evt;
  logic [W-1:0] load_val;

  assign tick_evt = sync2_q & ~prev_q;
  assign load_val = (load_sec > MAX_VAL) ? MAX_VAL : load_sec;

  // Commands with no effect in the current state are skipped, letting the next
  // lower-priority input act.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          remaining_d = '0;
        end else if (load) begin
          remaining_d = load_val;
        end else if (start && remaining_q != '0) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (tick_evt && remaining_q != '0) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == W'(1)) state_d = ST_DONE;
        end
      end
      ST_HOLD: begin
        if (clear) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (load) begin
          state_d     = ST_IDLE;
          remaining_d = load_val;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
        end else if (load) begin
          state_d     = ST_IDLE;
          remaining_d = load_val;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // Tick flops reset high so an idle-high tick at reset release is not an edge.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q     <= tick_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      running_q   <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
      expired_q   <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign remaining = remaining_q;
  assign bcd_tens  = 4'(remaining_q / TEN);
  assign bcd_ones  = 4'(remaining_q % TEN);
  assign running   = running_q;
  assign done      = done_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Self-checking bench for tick_countdown_timer: directed scenarios plus random
// commands and tick traffic compared against a behavioural model every cycle.
module tb_tick_countdown_timer;

  localparam int W       = 7;
  localparam int MAX_SEC = 99;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_HOLD = 2;
  localparam int P_DONE = 3;

  logic         freq_in;
  logic         reset_n;
  logic         tick_in;
  logic         load;
  logic [W-1:0] load_sec;
  logic         start;
  logic         pause;
  logic         clear;
  logic [W-1:0] remaining;
  logic [3:0]   bcd_tens;
  logic [3:0]   bcd_ones;
  logic         running;
  logic         done;
  logic         expired;

  tick_countdown_timer #(.MAX_SEC(MAX_SEC), .W(W)) dut (
    .freq_in  (freq_in),
    .reset_n  (reset_n),
    .tick_in  (tick_in),
    .load     (load),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .remaining(remaining),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .running  (running),
    .done     (done),
    .expired  (expired)
  );

  initial freq_in = 1'b0;
  always #5 freq_in = ~freq_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase, seconds left, last expired, and tick_in as sampled at the
  // previous three clock edges (t1 = one edge ago).
  int m_phase;
  int m_rem;
  bit m_expired;
  bit t1, t2, t3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".remaining"}, 32'(remaining), 32'(m_rem));
    check({where, ".bcd_tens"},  32'(bcd_tens),  32'(m_rem / 10));
    check({where, ".bcd_ones"},  32'(bcd_ones),  32'(m_rem % 10));
    check({where, ".running"},   32'(running),   32'(m_phase == P_RUN));
    check({where, ".done"},      32'(done),      32'(m_phase == P_DONE));
    check({where, ".expired"},   32'(expired),   32'(m_expired));
  endtask

  // One clock: advance the model from the inputs currently applied, let the
  // edge happen, compare, and return at the following falling edge.
  task automatic step();
    bit tick_event;
    int old_phase;
    int clamp;
    tick_event = t2 && !t3;  // a rise seen two and three edges back
    clamp      = (int'(load_sec) > MAX_SEC) ? MAX_SEC : int'(load_sec);
    old_phase  = m_phase;
    case (m_phase)
      P_IDLE: begin
        if (clear)                    m_rem = 0;
        else if (load)                m_rem = clamp;
        else if (start && m_rem > 0)  m_phase = P_RUN;
      end
      P_RUN: begin
        if (clear) begin
          m_phase = P_IDLE;
          m_rem   = 0;
        end else if (pause) begin
          m_phase = P_HOLD;
        end else if (tick_event) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_phase = P_DONE;
        end
      end
      P_HOLD: begin
        if (clear) begin
          m_phase = P_IDLE;
          m_rem   = 0;
        end else if (load) begin
          m_phase = P_IDLE;
          m_rem   = clamp;
        end else if (start) begin
          m_phase = P_RUN;
        end
      end
      default: begin
        if (clear) begin
          m_phase = P_IDLE;
          m_rem   = 0;
        end else if (load) begin
          m_phase = P_IDLE;
          m_rem   = clamp;
        end
      end
    endcase
    m_expired = (m_phase == P_DONE) && (old_phase != P_DONE);
    t3 = t2;
    t2 = t1;
    t1 = tick_in;
    @(posedge freq_in);
    #1;
    check_outputs("cyc");
    @(negedge freq_in);
  endtask

  task automatic idle_inputs();
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
  endtask

  // Assert reset between edges; outputs must drop without waiting for a clock.
  task automatic apply_reset();
    #2;
    reset_n = 1'b0;
    #1;
    m_phase   = P_IDLE;
    m_rem     = 0;
    m_expired = 1'b0;
    t1 = 1'b1;
    t2 = 1'b1;
    t3 = 1'b1;
    check_outputs("rst");
    idle_inputs();
    @(negedge freq_in);
    reset_n = 1'b1;
  endtask

  task automatic cmd_load(input int secs);
    load_sec = W'(secs);
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic cmd_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1;
    repeat (4) step();
    tick_in = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    reset_n  = 1'b1;
    tick_in  = 1'b1;
    load_sec = '0;
    idle_inputs();
    @(negedge freq_in);

    // Reset with idle-high tick, then sit for ten cycles: nothing moves.
    apply_reset();
    repeat (10) step();
    tick_in = 1'b0;
    repeat (4) step();

    // Load 5, start, five ticks down to expiry.
    cmd_load(5);
    cmd_start();
    repeat (5) tick_pulse();
    check("five.remaining_zero", 32'(remaining), 32'(0));
    check("five.done_high",      32'(done),      32'(1));

    // Clamp and BCD digits.
    cmd_load(120);
    check("clamp.remaining", 32'(remaining), 32'(99));
    check("clamp.tens",      32'(bcd_tens),  32'(9));
    check("clamp.ones",      32'(bcd_ones),  32'(9));
    cmd_load(37);
    check("bcd37.tens", 32'(bcd_tens), 32'(3));
    check("bcd37.ones", 32'(bcd_ones), 32'(7));

    // Load 10, two ticks, pause coinciding with a tick event, ticks in HOLD.
    cmd_load(10);
    cmd_start();
    repeat (2) tick_pulse();
    tick_in = 1'b1;
    step();
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    step();
    tick_in = 1'b0;
    repeat (4) step();
    repeat (4) tick_pulse();
    check("hold.remaining", 32'(remaining), 32'(8));
    cmd_start();
    tick_pulse();
    check("resume.remaining", 32'(remaining), 32'(7));

    // In RUN at 3, clear lands on the same cycle as a tick event.
    cmd_load(3);
    cmd_start();
    tick_in = 1'b1;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    tick_in = 1'b0;
    repeat (4) step();
    check("clr_tick.remaining", 32'(remaining), 32'(0));
    check("clr_tick.running",   32'(running),   32'(0));

    // Load 0 then start is ignored.
    cmd_load(0);
    cmd_start();
    check("zero_start.running", 32'(running), 32'(0));

    // Reset in the middle of a run at 6.
    cmd_load(6);
    cmd_start();
    step();
    apply_reset();
    check("midrst.remaining", 32'(remaining), 32'(0));
    step();

    // Random traffic: tick levels held 2..6 cycles, at most one command per cycle.
    begin
      int hold_left;
      hold_left = 3;
      tick_in   = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        int r;
        if (hold_left == 0) begin
          tick_in   = ~tick_in;
          hold_left = int'($urandom_range(2, 6));
        end
        hold_left--;
        idle_inputs();
        r = int'($urandom_range(0, 19));
        case (r)
          0:       clear = 1'b1;
          1, 2:    begin
                     load     = 1'b1;
                     load_sec = W'($urandom_range(0, 127));
                   end
          3:       pause = 1'b1;
          4, 5, 6: start = 1'b1;
          default: ;
        endcase
        if (i % 1000 == 999) begin
          apply_reset();
          tick_in   = 1'b1;
          hold_left = 3;
        end else begin
          step();
        end
      end
      idle_inputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_countdown_timer.md
# tick_countdown_timer

Seconds-resolution countdown timer that consumes the slow tick produced by the board's frequency divider and turns it into a loadable, pausable timeout for the vending-machine controller. It synchronises the asynchronous tick level onto the system clock, detects one event per tick period, counts a loaded number of seconds down to zero, and reports the remaining time in binary and BCD for the 7-segment display path. A single-cycle `expired` pulse and a `done` level tell the controller that the transaction window has closed.

## Interface
Parameters:
- `MAX_SEC`, 99: upper clamp for loaded value; legal range 1..99.
- `W`, 7: width of the seconds counter; must satisfy 2^W > MAX_SEC.

Ports (one clock; reset is asynchronous and active-low):
- `freq_in` input 1: system clock, 27 MHz board clock.
- `reset_n` input 1: asynchronous active-low reset.
- `tick_in` input 1: divider tick level, asynchronous to `freq_in`; one rising edge per second.
- `load` input 1: load `load_sec` into counter.
- `load_sec` input W: seconds to load.
- `start` input 1: begin or resume counting.
- `pause` input 1: suspend counting.
- `clear` input 1: abort, zero counter, return to IDLE.
- `remaining` output W: current seconds left.
- `bcd_tens` output 4: tens digit of `remaining`.
- `bcd_ones` output 4: ones digit of `remaining`.
- `running` output 1: high in RUN.
- `done` output 1: high in DONE.
- `expired` output 1: one-cycle pulse on entry to DONE.

## Operation
- Tick path: two-flop synchroniser on `tick_in`, then a third `prev` flop. Event = sync2 & ~prev. All three flops reset to 1, so an idle-high `tick_in` at reset release produces no event.
- States: IDLE, RUN, HOLD, DONE. Reset state is IDLE.
- Command priority within a cycle: `clear` > `load` > `pause` > `start` > tick event.
- IDLE:
  - `load` sets `remaining` = min(`load_sec`, MAX_SEC).
  - `start` with `remaining` > 0 goes to RUN.
  - `start` with `remaining` == 0 is ignored.
  - Tick events are ignored.
- RUN:
  - Each tick event decrements `remaining`.
  - A decrement from 1 to 0 goes to DONE.
  - `pause` goes to HOLD.
  - `clear` goes to IDLE with `remaining` = 0.
  - `load` is ignored.
- HOLD:
  - Tick events are ignored.
  - `start` goes to RUN.
  - `clear` goes to IDLE with `remaining` = 0.
  - `load` reloads the counter and goes to IDLE.
- DONE:
  - `remaining` stays at 0 and `done` is high.
  - `clear` goes to IDLE.
  - `load` reloads the counter and goes to IDLE.
  - `start` is ignored.
- `remaining` never wraps below 0. The counter is never decremented outside RUN.
- BCD outputs are combinational from `remaining`: tens = remaining / 10, ones = remaining % 10. Both digits are ≤ 9 for every legal value.
- `expired` is registered. It is high for exactly the one cycle in which the state first reads DONE.

## Timing
- Reset values:
  - `remaining` = 0, `bcd_tens` = 0, `bcd_ones` = 0.
  - `running` = 0, `done` = 0, `expired` = 0.
  - State = IDLE; sync/prev flops = 1.
- Reset mid-operation: all of the above apply immediately (asynchronous), with no `expired` pulse.
- Tick latency: with `tick_in` rising before clock edge k, sync2 is high after edge k+1. `remaining` decrements at edge k+2.
- Command latency: `load`, `start`, `pause`, and `clear` sampled at edge n take effect in state and outputs after edge n.
- Simultaneous tick and `pause` in RUN: go to HOLD with no decrement.
- Simultaneous tick and `clear`: `clear` wins.
- Final tick at edge m: after m, `remaining` = 0, `done` = 1, `expired` = 1, `running` = 0. After m+1, `expired` = 0.
- Tick pulses shorter than 2 `freq_in` cycles are not guaranteed to be detected. The divider's tick is always longer.

## Test plan
- Reset with `tick_in` held high, then release and hold for 10 cycles -> all outputs 0, no decrement.
- Load 5, start, apply 5 ticks -> `remaining` steps 5, 4, 3, 2, 1, 0 with each step 3 edges after its tick rise. On the last step, `expired` is high for 1 cycle, `done` = 1, and `remaining` = 0.
- Load 120 -> `remaining` = 99, `bcd_tens` = 9, `bcd_ones` = 9. Then load 37 -> `bcd_tens` = 3, `bcd_ones` = 7.
- Load 10, start, 2 ticks (8), pause, 4 ticks -> `remaining` stays 8. Then start and 1 tick -> 7.
- In RUN at 3, assert `clear` in the same cycle as a tick event -> IDLE, `remaining` = 0, `expired` never asserts.
- Load 0 then start -> state stays IDLE, `running` = 0. Assert reset mid-RUN at 6 -> all outputs 0 immediately.
